// File: rtl/dm_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// dm_access_ctrl_if
// Request/acknowledge data-memory bus between the MEM-stage access controller
// (master) and the data memory or its bus fabric (slave).
//
//   req    master->slave  request, held high until ack or abort
//   we     master->slave  1 = write
//   be     master->slave  byte enables, bit i = byte lane i
//   addr   master->slave  word-aligned byte address
//   wdata  master->slave  lane-replicated store data
//   ack    slave->master  one-cycle completion strobe
//   rdata  slave->master  read word, valid together with ack
// ----------------------------------------------------------------------------
interface dm_access_ctrl_if;
   logic        req;
   logic        we;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req, we, be, addr, wdata,
      input  ack, rdata
   );

   modport slave (
      input  req, we, be, addr, wdata,
      output ack, rdata
   );
endinterface

// File: rtl/dm_access_ctrl.sv
// ----------------------------------------------------------------------------
// dm_access_ctrl
// Sequences MEM-stage loads and stores onto a variable-latency req/ack data
// memory bus and holds the pipeline in stall until the access completes.
// Builds byte enables and lane-replicated store data, flags misaligned
// accesses, and hands the raw load word, byte offset and extension code to
// the W-stage load-extension unit.
//
// Parameters
//   TIMEOUT          ACCESS cycles to wait for ack before aborting (>= 2)
// Ports
//   i_clk            system clock, rising edge
//   i_rst_n          asynchronous active-low reset
//   i_load_en        MEM-stage instruction is a load
//   i_store_en       MEM-stage instruction is a store (wins over a load)
//   i_ext_option     load kind: 0 lw, 1 lbu, 2 lb, 3 lhu, 4 lh
//   i_st_size        store kind: 0 sw, 1 sb, 2 sh
//   i_addr           effective byte address
//   i_wdata          store data
//   o_stall          freeze PC/F/D/E/M pipeline registers
//   bus              data-memory bus (master side)
//   o_ld_valid       one-cycle pulse: load result ready for W stage
//   o_ld_data        raw read word (0 after a timed-out load)
//   o_ld_byte        byte offset of the completed load
//   o_ld_ext_option  extension code of the completed load
//   o_adel / o_ades  misaligned load / store, combinational
//   o_timeout_err    one-cycle pulse when the bus never acknowledged
// ----------------------------------------------------------------------------
module dm_access_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_load_en,
   input  logic                 i_store_en,
   input  logic [2:0]           i_ext_option,
   input  logic [1:0]           i_st_size,
   input  logic [31:0]          i_addr,
   input  logic [31:0]          i_wdata,
   output logic                 o_stall,
   dm_access_ctrl_if.master     bus,
   output logic                 o_ld_valid,
   output logic [31:0]          o_ld_data,
   output logic [1:0]           o_ld_byte,
   output logic [2:0]           o_ld_ext_option,
   output logic                 o_adel,
   output logic                 o_ades,
   output logic                 o_timeout_err
);

   localparam int CW = $clog2(TIMEOUT + 1);
   // Counter value during the final ACCESS cycle (counter starts at 0).
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   localparam logic [1:0] K_WORD = 2'd0;
   localparam logic [1:0] K_HALF = 2'd1;
   localparam logic [1:0] K_BYTE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_DONE
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_bus_req;
   logic          r_bus_we;
   logic [3:0]    r_bus_be;
   logic [31:0]   r_bus_addr;
   logic [31:0]   r_bus_wdata;
   logic [1:0]    r_pend_byte;
   logic [2:0]    r_pend_ext;
   logic          r_ld_valid;
   logic [31:0]   r_ld_data;
   logic [1:0]    r_ld_byte;
   logic [2:0]    r_ld_ext;
   logic          r_timeout_err;

   logic [1:0]    w_kind;
   logic          w_misaligned;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic          w_is_idle;
   logic          w_start;

   // Access width. The store decode is used whenever store_en is high, so a
   // simultaneous load is ignored. Unlisted codes behave as full words.
   always_comb begin
      w_kind = K_WORD;
      if (i_store_en) begin
         case (i_st_size)
            2'd1:    w_kind = K_BYTE;
            2'd2:    w_kind = K_HALF;
            default: w_kind = K_WORD;
         endcase
      end else begin
         case (i_ext_option)
            3'd1, 3'd2: w_kind = K_BYTE;
            3'd3, 3'd4: w_kind = K_HALF;
            default:    w_kind = K_WORD;
         endcase
      end
   end

   assign w_misaligned = ((w_kind == K_WORD) && (i_addr[1:0] != 2'b00)) ||
                         ((w_kind == K_HALF) && i_addr[0]);

   // Loads always fetch the whole word; the W stage picks the lanes.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = i_wdata;
      if (i_store_en) begin
         case (w_kind)
            K_BYTE: begin
               w_be    = 4'b0001 << i_addr[1:0];
               w_wdata = {4{i_wdata[7:0]}};
            end
            K_HALF: begin
               w_be    = i_addr[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{i_wdata[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = i_wdata;
            end
         endcase
      end
   end

   assign w_is_idle = (r_state == S_IDLE);
   assign w_start   = w_is_idle && (i_load_en || i_store_en) && !w_misaligned;

   // Combinational outputs are forced low while reset is asserted so the
   // pipeline is released immediately, even if an enable is still high.
   assign o_adel  = i_rst_n && w_is_idle && i_load_en && !i_store_en && w_misaligned;
   assign o_ades  = i_rst_n && w_is_idle && i_store_en && w_misaligned;
   assign o_stall = i_rst_n && (w_start || (r_state == S_ACCESS));

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_cnt         <= '0;
         r_bus_req     <= 1'b0;
         r_bus_we      <= 1'b0;
         r_bus_be      <= 4'b0000;
         r_bus_addr    <= 32'h0;
         r_bus_wdata   <= 32'h0;
         r_pend_byte   <= 2'b00;
         r_pend_ext    <= 3'b000;
         r_ld_valid    <= 1'b0;
         r_ld_data     <= 32'h0;
         r_ld_byte     <= 2'b00;
         r_ld_ext      <= 3'b000;
         r_timeout_err <= 1'b0;
      end else begin
         r_ld_valid    <= 1'b0;
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= i_store_en;
                  r_bus_be    <= w_be;
                  r_bus_addr  <= {i_addr[31:2], 2'b00};
                  r_bus_wdata <= w_wdata;
                  r_pend_byte <= i_addr[1:0];
                  r_pend_ext  <= i_ext_option;
                  r_cnt       <= '0;
                  r_state     <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_cnt <= r_cnt + CNT_ONE;
               // Ack is checked first so an ack in the last cycle completes normally.
               if (bus.ack) begin
                  r_bus_req <= 1'b0;
                  if (!r_bus_we) begin
                     r_ld_valid <= 1'b1;
                     r_ld_data  <= bus.rdata;
                     r_ld_byte  <= r_pend_byte;
                     r_ld_ext   <= r_pend_ext;
                  end
                  r_state <= S_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_bus_req     <= 1'b0;
                  r_timeout_err <= 1'b1;
                  if (!r_bus_we) begin
                     r_ld_valid <= 1'b1;
                     r_ld_data  <= 32'h0;
                     r_ld_byte  <= r_pend_byte;
                     r_ld_ext   <= r_pend_ext;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // Pipeline advances on this edge; inputs are not sampled here.
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req         = r_bus_req;
   assign bus.we          = r_bus_we;
   assign bus.be          = r_bus_be;
   assign bus.addr        = r_bus_addr;
   assign bus.wdata       = r_bus_wdata;
   assign o_ld_valid      = r_ld_valid;
   assign o_ld_data       = r_ld_data;
   assign o_ld_byte       = r_ld_byte;
   assign o_ld_ext_option = r_ld_ext;
   assign o_timeout_err   = r_timeout_err;

endmodule
